// File: rtl/dff_bank_arbiter_if.sv
// Requester/bank bundle for the two-port DFF bank arbiter.
// The testbench drives the master side; the arbiter is the slave.
interface dff_bank_arbiter_if #(
   parameter int DW = 8
);
   logic          i_req0;
   logic [DW-1:0] i_d0;
   logic          o_ack0;
   logic          i_req1;
   logic [DW-1:0] i_d1;
   logic          o_ack1;
   logic [DW-1:0] o_q;
   logic          o_en;
   logic          o_owner;
   logic          o_busy;
   logic [7:0]    o_wr_cnt;

   modport master (
      output i_req0, i_d0, i_req1, i_d1,
      input  o_ack0, o_ack1, o_q, o_en,
      input  o_owner, o_busy, o_wr_cnt
   );

   modport slave (
      input  i_req0, i_d0, i_req1, i_d1,
      output o_ack0, o_ack1, o_q, o_en,
      output o_owner, o_busy, o_wr_cnt
   );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter granting two requesters write access to a
// shared DFF bank; one write per IDLE->WRITE->ACK pass.
module dff_bank_arbiter #(
   parameter int DW = 8
) (
   input  logic               i_clk,
   input  logic               i_clr,
   dff_bank_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      ACK   = 2'd2
   } state_t;

   state_t        state_q;
   logic [DW-1:0] buf_q;
   logic [DW-1:0] q_q;
   logic          en_q;
   logic          ack0_q;
   logic          ack1_q;
   logic          owner_q;
   logic          busy_q;
   logic [7:0]    cnt_q;

   logic          any_req_d;
   logic          gnt_d;

   // On a tie the requester that did not win last time gets the bank.
   always_comb begin
      any_req_d = bus.i_req0 | bus.i_req1;
      gnt_d     = bus.i_req1;
      if (bus.i_req0 && bus.i_req1)
         gnt_d = ~owner_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         state_q <= IDLE;
         buf_q   <= '0;
         q_q     <= '0;
         en_q    <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         owner_q <= 1'b1;
         busy_q  <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         en_q   <= 1'b0;
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (any_req_d) begin
                  owner_q <= gnt_d;
                  buf_q   <= gnt_d ? bus.i_d1 : bus.i_d0;
                  en_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= WRITE;
               end
            end
            WRITE: begin
               q_q     <= buf_q;
               ack0_q  <= ~owner_q;
               ack1_q  <= owner_q;
               state_q <= ACK;
            end
            ACK: begin
               cnt_q   <= cnt_q + 8'd1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_q      = q_q;
   assign bus.o_en     = en_q;
   assign bus.o_ack0   = ack0_q;
   assign bus.o_ack1   = ack1_q;
   assign bus.o_owner  = owner_q;
   assign bus.o_busy   = busy_q;
   assign bus.o_wr_cnt = cnt_q;

endmodule
